// File: rtl/tdm_pkg.sv
// Shared TDM datapath package: default geometry, counter-width helper and the
// receive-side FSM state encoding, also used by the TDM multiplier.
package tdm_pkg;

    localparam int unsigned TDM_C_WIDTH   = 32;
    localparam int unsigned TDM_NUM_UNITS = 8;

    typedef enum logic {
        StHunt    = 1'b0,
        StCollect = 1'b1
    } tdm_state_e;

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot counter for the TDM deserialiser: increment, restart-to-1 (new slot 0
// already captured) and clear, with an is_last flag for the final slot.
module tdm_slot_ctr #(
    parameter int unsigned NUM_UNITS = 8,
    parameter int unsigned CNT_W     = 3
) (
    input  logic             ctl_clk,
    input  logic             ctl_rst,
    input  logic             inc_i,
    input  logic             restart_i,
    input  logic             clear_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             is_last_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (restart_i) begin
            cnt_d = CNT_W'(1);
        end else if (inc_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge ctl_clk or negedge ctl_rst) begin
        if (!ctl_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign is_last_o = (cnt_q == CNT_W'(NUM_UNITS - 1));

endmodule

// File: rtl/tdm_deser.sv
// TDM deserialiser: gathers NUM_UNITS product beats (slot 0 first) into one
// packed frame. Optional per-beat slot checking under TDM_DESER_SLOT_CHECK_EN.
module tdm_deser
    import tdm_pkg::*;
#(
    parameter int unsigned C_WIDTH   = TDM_C_WIDTH,
    parameter int unsigned NUM_UNITS = TDM_NUM_UNITS,
    localparam int unsigned CNT_W    = cnt_w(NUM_UNITS)
) (
    input  logic                         ctl_clk,
    input  logic                         ctl_rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_sof,
    input  logic [CNT_W-1:0]             in_slot,
    input  logic [C_WIDTH-1:0]           in_data,
    output logic [C_WIDTH*NUM_UNITS-1:0] products,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         frame_err,
    output logic [15:0]                  frame_cnt
);

    tdm_state_e                             state_q, state_d;
    logic [NUM_UNITS-2:0][C_WIDTH-1:0]      shadow_q;
    logic [C_WIDTH*NUM_UNITS-1:0]           products_q;
    logic                                   out_valid_q, err_q, err_d;
    logic [15:0]                            frame_cnt_q;
    logic [CNT_W-1:0]                       slot_cnt, widx;
    logic                                   cnt_last, cnt_inc, cnt_restart, cnt_clear;
    logic                                   accept, xfer, commit, shadow_we;
    logic                                   sof_slot_bad, mid_slot_bad;

`ifdef TDM_DESER_SLOT_CHECK_EN
    assign sof_slot_bad = (in_slot != '0);
    assign mid_slot_bad = (in_slot != slot_cnt);
`else
    logic unused_slot_parity;
    assign unused_slot_parity = ^in_slot;
    assign sof_slot_bad       = 1'b0;
    assign mid_slot_bad       = 1'b0;
`endif

    tdm_slot_ctr #(
        .NUM_UNITS (NUM_UNITS),
        .CNT_W     (CNT_W)
    ) u_slot_ctr (
        .ctl_clk   (ctl_clk),
        .ctl_rst   (ctl_rst),
        .inc_i     (cnt_inc),
        .restart_i (cnt_restart),
        .clear_i   (cnt_clear),
        .cnt_o     (slot_cnt),
        .is_last_o (cnt_last)
    );

    // Only the final beat can stall: it needs the output register to be free.
    assign in_ready = !((state_q == StCollect) && cnt_last && out_valid_q && !out_ready);
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid_q && out_ready;
    assign widx     = in_sof ? '0 : slot_cnt;

    always_comb begin
        state_d     = state_q;
        cnt_inc     = 1'b0;
        cnt_restart = 1'b0;
        cnt_clear   = 1'b0;
        err_d       = 1'b0;
        commit      = 1'b0;
        shadow_we   = 1'b0;
        if (accept) begin
            if (in_sof) begin
                err_d = (state_q == StCollect);
                if (sof_slot_bad) begin
                    err_d     = 1'b1;
                    cnt_clear = 1'b1;
                    state_d   = StHunt;
                end else begin
                    shadow_we   = 1'b1;
                    cnt_restart = 1'b1;
                    state_d     = StCollect;
                end
            end else if (state_q == StCollect) begin
                if (mid_slot_bad) begin
                    err_d     = 1'b1;
                    cnt_clear = 1'b1;
                    state_d   = StHunt;
                end else if (cnt_last) begin
                    commit    = 1'b1;
                    cnt_clear = 1'b1;
                    state_d   = StHunt;
                end else begin
                    shadow_we = 1'b1;
                    cnt_inc   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge ctl_clk or negedge ctl_rst) begin
        if (!ctl_rst) begin
            state_q     <= StHunt;
            shadow_q    <= '0;
            products_q  <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            for (int i = 0; i < NUM_UNITS - 1; i++) begin
                if (shadow_we && (widx == CNT_W'(i))) begin
                    shadow_q[i] <= in_data;
                end
            end
            if (commit) begin
                products_q  <= {in_data, shadow_q};
                out_valid_q <= 1'b1;
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end else if (xfer) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign products  = products_q;
    assign out_valid = out_valid_q;
    assign frame_err = err_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_tdm_deser.sv
// Self-checking bench for tdm_deser: queue-based frame model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_tdm_deser;

    localparam int unsigned CW = 32;
    localparam int unsigned NU = 8;

    logic           ctl_clk = 1'b0;
    logic           ctl_rst = 1'b1;
    logic           in_valid = 1'b0, in_sof = 1'b0, out_ready = 1'b1;
    logic [2:0]     in_slot = '0;
    logic [CW-1:0]  in_data = '0;
    logic           in_ready, out_valid, frame_err;
    logic [CW*NU-1:0] products;
    logic [15:0]    frame_cnt;

    int n_total = 0;
    int n_pass  = 0;
    int err_pulses = 0;
    bit started = 1'b0;

    always #5 ctl_clk = ~ctl_clk;

    tdm_deser #(.C_WIDTH(CW), .NUM_UNITS(NU)) dut (
        .ctl_clk   (ctl_clk),
        .ctl_rst   (ctl_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sof    (in_sof),
        .in_slot   (in_slot),
        .in_data   (in_data),
        .products  (products),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt)
    );

    task automatic check(input string name, input logic [CW*NU-1:0] act,
                         input logic [CW*NU-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: beats gathered in a queue, frame emitted when 8 are held.
    logic [CW-1:0]    m_cur[$];
    bit               m_hunt = 1'b1;
    logic [CW*NU-1:0] m_products = '0;
    bit               m_ov = 1'b0, m_err = 1'b0;
    logic [15:0]      m_cnt = '0;
`ifdef TDM_DESER_SLOT_CHECK_EN
    localparam bit SlotCheck = 1'b1;
`else
    localparam bit SlotCheck = 1'b0;
`endif

    function automatic bit model_ready();
        return !(!m_hunt && m_cur.size() == NU - 1 && m_ov && !out_ready);
    endfunction

    always @(posedge ctl_clk or negedge ctl_rst) begin
        if (!ctl_rst) begin
            m_cur.delete();
            m_hunt = 1'b1; m_products = '0; m_ov = 1'b0; m_err = 1'b0; m_cnt = '0;
        end else begin
            bit acc, xf, err, cm;
            acc = in_valid && model_ready();
            xf  = m_ov && out_ready;
            err = 1'b0; cm = 1'b0;
            if (acc) begin
                if (in_sof) begin
                    if (!m_hunt) err = 1'b1;
                    m_cur.delete();
                    if (SlotCheck && in_slot != 0) begin
                        err = 1'b1; m_hunt = 1'b1;
                    end else begin
                        m_cur.push_back(in_data); m_hunt = 1'b0;
                    end
                end else if (!m_hunt) begin
                    if (SlotCheck && int'(in_slot) != m_cur.size()) begin
                        err = 1'b1; m_hunt = 1'b1; m_cur.delete();
                    end else begin
                        m_cur.push_back(in_data);
                        if (m_cur.size() == NU) begin
                            for (int i = 0; i < NU; i++) m_products[i*CW +: CW] = m_cur[i];
                            m_cur.delete(); m_hunt = 1'b1; cm = 1'b1; m_cnt = m_cnt + 16'd1;
                        end
                    end
                end
            end
            m_ov  = cm ? 1'b1 : (xf ? 1'b0 : m_ov);
            m_err = err;
        end
    end

    always @(negedge ctl_clk) begin
        if (frame_err === 1'b1) err_pulses++;
        if (started) begin
            check("cyc_products",  products,  m_products);
            check("cyc_out_valid", {255'b0, out_valid}, {255'b0, m_ov});
            check("cyc_frame_err", {255'b0, frame_err}, {255'b0, m_err});
            check("cyc_frame_cnt", {240'b0, frame_cnt}, {240'b0, m_cnt});
            check("cyc_in_ready",  {255'b0, in_ready},  {255'b0, model_ready()});
        end
    end

    task automatic step();
        @(posedge ctl_clk); #1;
    endtask

    task automatic do_reset();
        ctl_rst = 1'b0; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge ctl_clk);
        #1 ctl_rst = 1'b1;
        step();
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [CW-1:0] d, input bit sof, input logic [2:0] slot);
        bit rdy;
        in_valid = 1'b1; in_data = d; in_sof = sof; in_slot = slot;
        for (int k = 0; k < 50; k++) begin
            @(negedge ctl_clk) rdy = in_ready;
            @(posedge ctl_clk);
            if (rdy) break;
            if (k == 49) check("send_timeout", 256'd0, 256'd1);
        end
        #1 in_valid = 1'b0; in_sof = 1'b0;
    endtask

    task automatic send_frame(input logic [CW-1:0] base);
        for (int i = 0; i < NU; i++) send(base + CW'(i), i == 0, 3'(i));
    endtask

    initial begin
        int e0;
        #2 ctl_rst = 1'b0;
        #20 ctl_rst = 1'b1;
        step();
        started = 1'b1;

        // 1: reset / idle
        @(negedge ctl_clk);
        check("rst_products", products, '0);
        check("rst_out_valid", {255'b0, out_valid}, 256'd0);
        check("rst_in_ready", {255'b0, in_ready}, 256'd1);
        check("rst_frame_cnt", {240'b0, frame_cnt}, 256'd0);
        step();

        // 2: full frame, out_valid the cycle after beat 7
        for (int i = 0; i < NU - 1; i++) send(32'h100 + i, i == 0, 3'(i));
        check("full_ov_before_last", {255'b0, out_valid}, 256'd0);
        send(32'h107, 1'b0, 3'd7);
        @(negedge ctl_clk);
        check("full_ov", {255'b0, out_valid}, 256'd1);
        check("full_slot0", {224'b0, products[31:0]}, 256'h100);
        check("full_slot7", {224'b0, products[255:224]}, 256'h107);
        check("full_cnt", {240'b0, frame_cnt}, 256'd1);
        step();

        // 3: short frame then a good one
        do_reset();
        e0 = err_pulses;
        for (int i = 0; i < 5; i++) send(32'h50 + i, i == 0, 3'(i));
        send_frame(32'hA0);
        @(negedge ctl_clk);
        check("short_err_pulses", 256'(err_pulses - e0), 256'd1);
        check("short_slot0", {224'b0, products[31:0]}, 256'hA0);
        check("short_slot3", {224'b0, products[127:96]}, 256'hA3);
        check("short_slot7", {224'b0, products[255:224]}, 256'hA7);
        check("short_cnt", {240'b0, frame_cnt}, 256'd1);
        step();

        // 4: backpressure on the second frame's final beat
        do_reset();
        out_ready = 1'b0;
        send_frame(32'h200);
        for (int i = 0; i < NU - 1; i++) send(32'h300 + i, i == 0, 3'(i));
        fork
            send(32'h307, 1'b0, 3'd7);
            begin
                repeat (5) @(negedge ctl_clk);
                check("bp_in_ready", {255'b0, in_ready}, 256'd0);
                check("bp_hold_slot0", {224'b0, products[31:0]}, 256'h200);
                check("bp_hold_ov", {255'b0, out_valid}, 256'd1);
                step();
                out_ready = 1'b1;
            end
        join
        @(negedge ctl_clk);
        check("bp_release_ov", {255'b0, out_valid}, 256'd1);
        check("bp_release_slot0", {224'b0, products[31:0]}, 256'h300);
        check("bp_release_slot7", {224'b0, products[255:224]}, 256'h307);
        check("bp_cnt", {240'b0, frame_cnt}, 256'd2);
        step();
        @(negedge ctl_clk);
        check("bp_drain_ov", {255'b0, out_valid}, 256'd0);
        step();

        // 5: hunt discards non-sof beats
        do_reset();
        e0 = err_pulses;
        for (int i = 0; i < 3; i++) send(32'hDEAD0 + i, 1'b0, 3'(i));
        send_frame(32'h400);
        @(negedge ctl_clk);
        check("hunt_no_err", 256'(err_pulses - e0), 256'd0);
        check("hunt_slot0", {224'b0, products[31:0]}, 256'h400);
        check("hunt_cnt", {240'b0, frame_cnt}, 256'd1);
        step();

        // 6: wrong slot index on beat 2
        do_reset();
        e0 = err_pulses;
        for (int i = 0; i < NU; i++) send(32'h600 + i, i == 0, (i == 2) ? 3'd3 : 3'(i));
        repeat (2) @(negedge ctl_clk);
        check("slot_err_pulses", 256'(err_pulses - e0), SlotCheck ? 256'd1 : 256'd0);
        check("slot_cnt", {240'b0, frame_cnt}, SlotCheck ? 256'd0 : 256'd1);
        step();

        repeat (3) step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
